// File: rtl/mul32_seq.sv
// Sequential shift-and-add multiplier with optional accumulate (MUL / MLA).
// Retires one multiplier bit per clock; result and N/Z flags stay registered until the next completion.
module mul32_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  in_clk,
  input  logic                  in_reset_n,
  input  logic                  in_start,
  input  logic                  in_accumulate,
  input  logic [DATA_WIDTH-1:0] in_data0,
  input  logic [DATA_WIDTH-1:0] in_data1,
  input  logic [DATA_WIDTH-1:0] in_acc,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_negative,
  output logic                  out_zero,
  output logic                  out_busy,
  output logic                  out_done
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, CALC} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] mcand_q;
  logic [DATA_WIDTH-1:0] mplier_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] acc_d;
  logic [CW-1:0]         cnt_q;
  logic                  last;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  neg_q;
  logic                  zero_q;
  logic                  busy_q;
  logic                  done_q;

  // acc_d is the running sum after this edge's iteration; on the final edge it is the result.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
    last = (cnt_q == CW'(DATA_WIDTH - 1));
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_start) begin
            mcand_q  <= in_data0;
            mplier_q <= in_data1;
            acc_q    <= in_accumulate ? in_acc : '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // in_start is deliberately ignored here, including on the completion edge.
          if (last) begin
            data_q  <= acc_d;
            neg_q   <= acc_d[DATA_WIDTH-1];
            zero_q  <= (acc_d == '0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data     = data_q;
  assign out_negative = neg_q;
  assign out_zero     = zero_q;
  assign out_busy     = busy_q;
  assign out_done     = done_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Testbench for mul32_seq: a cycle-level arithmetic reference model checked every cycle,
// plus directed operations whose results are pinned to hand-computed literals.
module tb_mul32_seq;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic        accum = 1'b0;
  logic [31:0] data0 = '0;
  logic [31:0] data1 = '0;
  logic [31:0] accIn = '0;
  logic [31:0] outData;
  logic        outNeg;
  logic        outZero;
  logic        outBusy;
  logic        outDone;

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;

  mul32_seq #(.DATA_WIDTH(32)) dut (
    .in_clk        (clk),
    .in_reset_n    (rstN),
    .in_start      (start),
    .in_accumulate (accum),
    .in_data0      (data0),
    .in_data1      (data1),
    .in_acc        (accIn),
    .out_data      (outData),
    .out_negative  (outNeg),
    .out_zero      (outZero),
    .out_busy      (outBusy),
    .out_done      (outDone)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a started op yields (a*b + acc) mod 2^32 exactly 32 edges after the start edge.
  int          remaining = 0;
  logic [31:0] pendRes = '0;
  logic [31:0] expData = '0;
  logic        expNeg = 1'b0;
  logic        expZero = 1'b0;
  logic        expBusy = 1'b0;
  logic        expDone = 1'b0;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      remaining = 0;
      expData = '0;
      expNeg = 1'b0;
      expZero = 1'b0;
      expBusy = 1'b0;
      expDone = 1'b0;
    end else begin
      expDone = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          expData = pendRes;
          expNeg = pendRes[31];
          expZero = (pendRes == 32'd0);
          expDone = 1'b1;
          expBusy = 1'b0;
        end
      end else if (start) begin
        pendRes = data0 * data1 + (accum ? accIn : 32'd0);
        remaining = 32;
        expBusy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model data", outData, expData);
      checkOutput("model negative", 32'(outNeg), 32'(expNeg));
      checkOutput("model zero", 32'(outZero), 32'(expZero));
      checkOutput("model busy", 32'(outBusy), 32'(expBusy));
      checkOutput("model done", 32'(outDone), 32'(expDone));
      checkOutput("busy and done exclusive", 32'(outBusy & outDone), 32'd0);
    end
  end

  // Drives operands and a one-cycle start pulse; returns just after the start-sampling edge E0.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic acc);
    @(posedge clk); #1;
    data0 = a; data1 = b; accIn = c; accum = acc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (outDone) begin
        n = i;
        return;
      end
    end
    tests++;
    fails++;
    $display("[TB] FAIL %s timeout: got no done, expected done within 40 cycles", name);
  endtask

  task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic acc, input logic [31:0] expLit,
                       input logic expN, input logic expZ);
    int n;
    applyStimulus(a, b, c, acc);
    checkOutput({name, " busy after start"}, 32'(outBusy), 32'd1);
    waitDone(name, n);
    checkOutput({name, " latency"}, 32'(n), 32'd32);
    checkOutput({name, " data"}, outData, expLit);
    checkOutput({name, " negative"}, 32'(outNeg), 32'(expN));
    checkOutput({name, " zero"}, 32'(outZero), 32'(expZ));
    checkOutput({name, " busy at done"}, 32'(outBusy), 32'd0);
    @(posedge clk); #1;
    checkOutput({name, " done one cycle"}, 32'(outDone), 32'd0);
  endtask

  initial begin
    int doneCount;
    #2;
    checkOutput("reset data", outData, 32'd0);
    checkOutput("reset flags", {29'd0, outNeg, outZero, outBusy}, 32'd0);
    checkOutput("reset done", 32'(outDone), 32'd0);
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
    checkEn = 1'b1;

    runOp("mul 3*5", 32'd3, 32'd5, 32'd0, 1'b0, 32'h0000000F, 1'b0, 1'b0);
    runOp("mul -3*4", 32'hFFFFFFFD, 32'd4, 32'd0, 1'b0, 32'hFFFFFFF4, 1'b1, 1'b0);
    runOp("mul -1*-1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h00000001, 1'b0, 1'b0);
    runOp("mul 2^31*2", 32'h80000000, 32'd2, 32'd0, 1'b0, 32'h00000000, 1'b0, 1'b1);
    runOp("mla 7*6+100", 32'd7, 32'd6, 32'd100, 1'b1, 32'h0000008E, 1'b0, 1'b0);
    runOp("mla wrap", 32'h0000FFFF, 32'h00010001, 32'd1, 1'b1, 32'h00000000, 1'b0, 1'b1);
    runOp("mul ignores acc", 32'd7, 32'd6, 32'd100, 1'b0, 32'h0000002A, 1'b0, 1'b0);

    // Mid-operation starts and operand changes must not disturb the running op.
    @(posedge clk); #1;
    data0 = 32'h1234; data1 = 32'h10; accIn = 32'h55; accum = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin data0 = 32'hDEAD; data1 = 32'hBEEF; accIn = 32'h1; accum = 1'b1; end
      if (k == 4) begin start = 1'b1; data0 = 32'd7; data1 = 32'd7; end
      if (k == 5) start = 1'b0;
      if (k == 31) begin start = 1'b1; data0 = 32'h99; data1 = 32'h99; end
      if (k == 32) begin
        checkOutput("interfere done at E32", 32'(outDone), 32'd1);
        checkOutput("interfere data", outData, 32'h00012340);
        data0 = 32'h11; data1 = 32'd3; accum = 1'b0;
      end
      if (k == 33) begin
        start = 1'b0;
        checkOutput("E33 start accepted", 32'(outBusy), 32'd1);
      end
      if (k == 64) checkOutput("no early done", 32'(outDone), 32'd0);
      if (k == 65) begin
        checkOutput("E65 done", 32'(outDone), 32'd1);
        checkOutput("E65 data", outData, 32'h00000033);
      end
    end

    // Asynchronous reset in the middle of an operation.
    applyStimulus(32'hABCD, 32'h1357, 32'd0, 1'b0);
    repeat (11) @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    checkOutput("async reset data", outData, 32'd0);
    checkOutput("async reset busy", 32'(outBusy), 32'd0);
    checkOutput("async reset done", 32'(outDone), 32'd0);
    checkOutput("async reset flags", {30'd0, outNeg, outZero}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (outDone) doneCount++;
    end
    checkOutput("no done after reset", 32'(doneCount), 32'd0);
    runOp("mul 2*9", 32'd2, 32'd9, 32'd0, 1'b0, 32'h00000012, 1'b0, 1'b0);

    // Result hold while idle and during the next operation.
    repeat (100) @(posedge clk);
    #1;
    checkOutput("hold data idle", outData, 32'h00000012);
    applyStimulus(32'd3, 32'd5, 32'd0, 1'b0);
    repeat (31) @(posedge clk);
    #1;
    checkOutput("hold data during op", outData, 32'h00000012);
    checkOutput("no done at E31", 32'(outDone), 32'd0);
    @(posedge clk); #1;
    checkOutput("next op done", 32'(outDone), 32'd1);
    checkOutput("next op data", outData, 32'h0000000F);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
